// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode and FSM state encodings shared by the multi-cycle ALU.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_MUL = 3'd2,
      OP_DIV = 3'd3,
      OP_REM = 3'd4,
      OP_AND = 3'd5,
      OP_OR  = 3'd6,
      OP_XOR = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage
`default_nettype wire

// File: rtl/alu_div.sv
`default_nettype none
// ============================================================================
// Module      : alu_div
// Description : Unsigned restoring divider, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_div #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [CNT_W-1:0] r_cnt;
   logic             r_busy;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_quo;
   logic [WIDTH-1:0] r_dvs;
   logic [WIDTH:0]   w_trial;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;

   // Trial subtraction on the shifted partial remainder; the borrow bit decides restore.
   always_comb begin
      w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
      if (w_trial[WIDTH]) begin
         w_rem_nxt = {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
         w_quo_nxt = {r_quo[WIDTH-2:0], 1'b0};
      end else begin
         w_rem_nxt = w_trial[WIDTH-1:0];
         w_quo_nxt = {r_quo[WIDTH-2:0], 1'b1};
      end
   end

   // Done is flagged during the last step so the parent captures on the same edge.
   assign o_done      = r_busy && (r_cnt == CNT_W'(WIDTH - 1));
   assign o_quotient  = w_quo_nxt;
   assign o_remainder = w_rem_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_busy <= 1'b0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvs  <= '0;
      end else if (i_start) begin
         r_cnt  <= '0;
         r_busy <= 1'b1;
         r_rem  <= '0;
         r_quo  <= i_dividend;
         r_dvs  <= i_divisor;
      end else if (r_busy) begin
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         r_cnt  <= r_cnt + CNT_W'(1);
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : alu_mc
// Description : Valid/ready ALU; single-cycle ops plus iterative DIV/REM.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic [2:0]       operation,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] result,
   output logic             zero_o,
   output logic             err_o
);

   state_e           r_state;
   state_e           w_state_nxt;
   op_e              r_op;
   op_e              w_op;
   logic [WIDTH-1:0] r_result;
   logic [WIDTH-1:0] w_result_nxt;
   logic             r_zero;
   logic             w_zero_nxt;
   logic             r_err;
   logic             w_err_nxt;
   logic [WIDTH-1:0] w_alu;
   logic             w_alu_err;
   logic             w_accept;
   logic             w_retire;
   logic             w_start;
   logic             w_div_done;
   logic [WIDTH-1:0] w_quo;
   logic [WIDTH-1:0] w_rem;

   assign w_op     = op_e'(operation);
   assign ready_o  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && ready_i);
   assign valid_o  = (r_state == ST_DONE);
   assign w_accept = valid_i && ready_o;
   assign w_retire = valid_o && ready_i;
   assign w_start  = w_accept && ((w_op == OP_DIV) || (w_op == OP_REM)) && (operand_b != '0);
   assign result   = r_result;
   assign zero_o   = r_zero;
   assign err_o    = r_err;

   // Single-cycle result; DIV/REM entries only matter for the divide-by-zero case.
   always_comb begin
      w_alu     = '0;
      w_alu_err = 1'b0;
      case (w_op)
         OP_ADD: w_alu = operand_a + operand_b;
         OP_SUB: w_alu = operand_a - operand_b;
         OP_MUL: w_alu = operand_a * operand_b;
         OP_DIV: begin
            w_alu     = '1;
            w_alu_err = 1'b1;
         end
         OP_REM: begin
            w_alu     = operand_a;
            w_alu_err = 1'b1;
         end
         OP_AND: w_alu = operand_a & operand_b;
         OP_OR:  w_alu = operand_a | operand_b;
         OP_XOR: w_alu = operand_a ^ operand_b;
         default: w_alu = '0;
      endcase
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_result_nxt = r_result;
      w_zero_nxt   = r_zero;
      w_err_nxt    = r_err;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (w_accept) begin
               if (w_start) begin
                  w_state_nxt = ST_BUSY;
               end else begin
                  w_state_nxt  = ST_DONE;
                  w_result_nxt = w_alu;
                  w_zero_nxt   = (w_alu == '0);
                  w_err_nxt    = w_alu_err;
               end
            end else if (w_retire) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (w_div_done) begin
               w_state_nxt  = ST_DONE;
               w_result_nxt = (r_op == OP_DIV) ? w_quo : w_rem;
               w_zero_nxt   = (((r_op == OP_DIV) ? w_quo : w_rem) == '0);
               w_err_nxt    = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state  <= ST_IDLE;
         r_op     <= OP_ADD;
         r_result <= '0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_result <= w_result_nxt;
         r_zero   <= w_zero_nxt;
         r_err    <= w_err_nxt;
         if (w_accept) begin
            r_op <= w_op;
         end
      end
   end

   alu_div #(
      .WIDTH (WIDTH)
   ) u_div (
      .clk         (clk_i),
      .rst_n       (rst_i),
      .i_start     (w_start),
      .i_dividend  (operand_a),
      .i_divisor   (operand_b),
      .o_done      (w_div_done),
      .o_quotient  (w_quo),
      .o_remainder (w_rem)
   );

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_mc
// Description : Directed vector bench for alu_mc at WIDTH = 32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
   import alu_pkg::*;

   localparam int W = 32;
   localparam int NV = 15;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic          ready_o;
   logic [W-1:0]  operand_a;
   logic [W-1:0]  operand_b;
   logic [2:0]    operation;
   logic          valid_o;
   logic          ready_i;
   logic [W-1:0]  result;
   logic          zero_o;
   logic          err_o;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      logic        e;
      int          lat;
   } vec_t;

   vec_t vecs[NV];

   alu_mc #(
      .WIDTH (W)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .valid_i   (valid_i),
      .ready_o   (ready_o),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .operation (operation),
      .valid_o   (valid_o),
      .ready_i   (ready_i),
      .result    (result),
      .zero_o    (zero_o),
      .err_o     (err_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v);
      int   lat;
      logic busy_bad;
      @(negedge clk_i);
      operation = v.op;
      operand_a = v.a;
      operand_b = v.b;
      valid_i   = 1'b1;
      ready_i   = 1'b1;
      @(posedge clk_i);
      #1;
      valid_i  = 1'b0;
      lat      = 1;
      busy_bad = 1'b0;
      while (!valid_o && lat < 100) begin
         if (ready_o) busy_bad = 1'b1;
         @(posedge clk_i);
         #1;
         lat++;
      end
      chk("result", result, v.res);
      chk("zero_o", {31'b0, zero_o}, {31'b0, v.z});
      chk("err_o", {31'b0, err_o}, {31'b0, v.e});
      chk("latency", lat, v.lat);
      if (v.lat > 1) chk("ready_low_busy", {31'b0, busy_bad}, 32'd0);
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      logic seen;
      vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h1,        32'h0,         1'b1, 1'b0, 1};
      vecs[1]  = '{OP_SUB, 32'd5,         32'd7,        32'hFFFF_FFFE, 1'b0, 1'b0, 1};
      vecs[2]  = '{OP_SUB, 32'd3,         32'd3,        32'h0,         1'b1, 1'b0, 1};
      vecs[3]  = '{OP_MUL, 32'd1234,      32'd10,       32'd12340,     1'b0, 1'b0, 1};
      vecs[4]  = '{OP_MUL, 32'h1_0000,    32'h1_0000,   32'h0,         1'b1, 1'b0, 1};
      vecs[5]  = '{OP_DIV, 32'd100,       32'd7,        32'd14,        1'b0, 1'b0, 33};
      vecs[6]  = '{OP_REM, 32'd100,       32'd7,        32'd2,         1'b0, 1'b0, 33};
      vecs[7]  = '{OP_DIV, 32'h55,        32'd0,        32'hFFFF_FFFF, 1'b0, 1'b1, 1};
      vecs[8]  = '{OP_REM, 32'h55,        32'd0,        32'h55,        1'b0, 1'b1, 1};
      vecs[9]  = '{OP_DIV, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 1'b0, 1'b0, 33};
      vecs[10] = '{OP_DIV, 32'd7,         32'd100,      32'd0,         1'b1, 1'b0, 33};
      vecs[11] = '{OP_REM, 32'd7,         32'd100,      32'd7,         1'b0, 1'b0, 33};
      vecs[12] = '{OP_AND, 32'hFF00,      32'h0F0F,     32'h0F00,      1'b0, 1'b0, 1};
      vecs[13] = '{OP_OR,  32'hF0,        32'h0F,       32'hFF,        1'b0, 1'b0, 1};
      vecs[14] = '{OP_XOR, 32'hF0F0,      32'h0FF0,     32'hFF00,      1'b0, 1'b0, 1};

      rst_i     = 1'b0;
      valid_i   = 1'b0;
      ready_i   = 1'b1;
      operand_a = '0;
      operand_b = '0;
      operation = 3'd0;
      #3;
      chk("rst_ready_o", {31'b0, ready_o}, 32'd1);
      chk("rst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_zero_o", {31'b0, zero_o}, 32'd0);
      chk("rst_err_o", {31'b0, err_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;

      for (int i = 0; i < NV; i++) run_vec(vecs[i]);

      // Back-to-back single-cycle ops with same-cycle drain and refill.
      @(negedge clk_i);
      operation = OP_XOR; operand_a = 32'hF0F0; operand_b = 32'h0FF0;
      valid_i = 1'b1; ready_i = 1'b1;
      @(posedge clk_i); #1;
      chk("b2b_valid1", {31'b0, valid_o}, 32'd1);
      chk("b2b_result1", result, 32'hFF00);
      chk("b2b_ready", {31'b0, ready_o}, 32'd1);
      operation = OP_AND; operand_a = 32'hFF00; operand_b = 32'h0F0F;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      chk("b2b_valid2", {31'b0, valid_o}, 32'd1);
      chk("b2b_result2", result, 32'h0F00);
      @(posedge clk_i); #1;
      chk("b2b_idle", {31'b0, valid_o}, 32'd0);

      // Back-pressure: result held, pending request ignored until ready_i rises.
      @(negedge clk_i);
      operation = OP_MUL; operand_a = 32'h1_0000; operand_b = 32'h1_0000;
      valid_i = 1'b1; ready_i = 1'b0;
      @(posedge clk_i); #1;
      operation = OP_ADD; operand_a = 32'd1; operand_b = 32'd1;
      for (int k = 0; k < 5; k++) begin
         chk("hold_valid", {31'b0, valid_o}, 32'd1);
         chk("hold_result", result, 32'd0);
         chk("hold_zero", {31'b0, zero_o}, 32'd1);
         chk("hold_ready_o", {31'b0, ready_o}, 32'd0);
         @(posedge clk_i); #1;
      end
      @(negedge clk_i);
      ready_i = 1'b1;
      #1;
      chk("hold_release_ready", {31'b0, ready_o}, 32'd1);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      chk("refill_valid", {31'b0, valid_o}, 32'd1);
      chk("refill_result", result, 32'd2);
      chk("refill_zero", {31'b0, zero_o}, 32'd0);
      @(posedge clk_i); #1;
      chk("refill_idle", {31'b0, valid_o}, 32'd0);

      // Reset in the middle of a division abandons it.
      @(negedge clk_i);
      operation = OP_DIV; operand_a = 32'd1000; operand_b = 32'd3;
      valid_i = 1'b1; ready_i = 1'b1;
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("midrst_ready_o", {31'b0, ready_o}, 32'd1);
      chk("midrst_valid_o", {31'b0, valid_o}, 32'd0);
      chk("midrst_result", result, 32'd0);
      chk("midrst_zero_o", {31'b0, zero_o}, 32'd0);
      chk("midrst_err_o", {31'b0, err_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (valid_o) seen = 1'b1;
      end
      chk("no_valid_after_rst", {31'b0, seen}, 32'd0);
      run_vec('{OP_ADD, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
